blink_counter: RTL

Upstream stage of the LED path in the blinky SoC. A prescaler divides `clk` down to a slow step rate, and an 8-bit counter advances on each step. The counter runs in up-wrap, down-wrap, ping-pong or hold mode. Its `count` output drives the LED controller's 8-bit `count` input directly, and the step and wrap pulses are available to other SoC logic.

---
 rtl/blinky_pkg.sv | 31 +++
 rtl/tick_gen.sv | 46 ++++
 rtl/blink_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/blinky_pkg.sv
// Shared types and constants for the blinky LED path.
//   count_mode_t : counter stepping mode, encoded to match the 2-bit mode input
//   pp_dir_t     : ping-pong direction state
//   LED_W        : counter width expected by the LED controller
package blinky_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } count_mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } pp_dir_t;

  localparam int LED_W = 8;

  // Width of a counter that must hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : blinky_pkg

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV_MAX+1 enabled cycles.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : run enable; low freezes the divider
//   clr  : synchronous restart of the divider (driven by the counter load)
//   tick : high in the enabled cycle where the divider sits at DIV_MAX
module tick_gen
  import blinky_pkg::*;
#(
  parameter int unsigned DIV_MAX = 24_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = cnt_width(DIV_MAX);
  localparam logic [DW-1:0] DIV_TERM = DW'(DIV_MAX);

  logic [DW-1:0] div_cnt;
  logic          at_term;

  assign at_term = (div_cnt == DIV_TERM);

  // tick is combinational so the counter steps on the same edge that
  // wraps the divider; the counter registers it into its outputs.
  assign tick = en && at_term;

  // Divider register: rst > clr > run > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (at_term) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule : tick_gen

// File: rtl/blink_counter.sv
// Prescaled 8-bit LED counter with up, down, ping-pong and hold modes.
//   clk      : sole clock
//   rst      : synchronous active-high reset
//   en       : prescaler run enable; low freezes prescaler and counter
//   mode     : 00 up, 01 down, 10 ping-pong, 11 hold
//   load     : synchronous load strobe (wins over a coincident tick)
//   load_val : value taken on load
//   count    : registered counter value
//   step     : registered pulse in the cycle count shows a stepped value
//   wrap     : registered pulse with step on a wrap or ping-pong reversal
module blink_counter
  import blinky_pkg::*;
#(
  parameter int unsigned DIV_MAX = 24_999_999,
  parameter int unsigned WIDTH   = LED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             tick;
  count_mode_t      mode_e;
  pp_dir_t          dir_q, dir_d;
  logic [WIDTH-1:0] count_d;
  logic             step_d, wrap_d;

  assign mode_e = count_mode_t'(mode);

  // Prescaler; a load restarts the step period.
  tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir_q <= DIR_UP;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      dir_q <= dir_d;
      step  <= step_d;
      wrap  <= wrap_d;
    end
  end

  // Next count, direction and pulses. A load discards a coincident tick
  // and leaves the ping-pong direction alone; the direction only moves on
  // ping-pong ticks so it survives mode changes and enable gaps.
  always_comb begin
    count_d = count;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      unique case (mode_e)
        MODE_UP: begin
          count_d = count + CNT_ONE;
          step_d  = 1'b1;
          wrap_d  = (count == CNT_MAX);
        end
        MODE_DOWN: begin
          count_d = count - CNT_ONE;
          step_d  = 1'b1;
          wrap_d  = (count == '0);
        end
        MODE_PINGPONG: begin
          step_d = 1'b1;
          unique case (dir_q)
            DIR_UP: begin
              if (count == CNT_MAX) begin
                // Reverse at the top without repeating the endpoint.
                count_d = count - CNT_ONE;
                dir_d   = DIR_DN;
                wrap_d  = 1'b1;
              end else begin
                count_d = count + CNT_ONE;
              end
            end
            DIR_DN: begin
              if (count == '0) begin
                // Reverse at the bottom without repeating the endpoint.
                count_d = count + CNT_ONE;
                dir_d   = DIR_UP;
                wrap_d  = 1'b1;
              end else begin
                count_d = count - CNT_ONE;
              end
            end
            default: begin
              dir_d = DIR_UP;
            end
          endcase
        end
        MODE_HOLD: begin
          count_d = count;
        end
        default: begin
          count_d = count;
        end
      endcase
    end
  end

endmodule : blink_counter
